// File: rtl/acc_regfile_sb.sv
// Accelerator register file with a per-register pending scoreboard.
// Reads of a pending register stall until the matching FPU write-back arrives.
module acc_regfile_sb #(
  parameter  int NREGS  = 32,
  parameter  int DATA_W = 32,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rreq_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              rwait_o,
  input  logic              wren_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              issue_valid_i,
  input  logic [AW-1:0]     issue_tag_i,
  output logic [NREGS-1:0]  pending_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state;
  logic [AW-1:0]       sraddr;
  logic [DATA_W-1:0]   mem [NREGS];
  logic [NREGS-1:0]    pending_nxt;
  logic                wr_hit_rd;
  logic                wr_hit_wait;
  logic                rd_blocked;
  logic                issue_err;

  // Read blocking sees this cycle's write-clear but not this cycle's issue-set.
  always_comb begin
    wr_hit_rd   = wren_i && (waddr_i == raddr_i);
    wr_hit_wait = wren_i && (waddr_i == sraddr);
    rd_blocked  = pending_o[raddr_i] && !wr_hit_rd;
    issue_err   = issue_valid_i && pending_o[issue_tag_i]
                  && !(wren_i && (waddr_i == issue_tag_i));
    pending_nxt = pending_o;
    if (wren_i)
      pending_nxt[waddr_i] = 1'b0;
    if (issue_valid_i)
      pending_nxt[issue_tag_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else if (wren_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_o <= '0;
      busy_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      pending_o <= pending_nxt;
      busy_o    <= |pending_nxt;
      if (issue_err)
        err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      sraddr   <= '0;
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
      rwait_o  <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          rwait_o <= 1'b0;
          if (rreq_i) begin
            if (rd_blocked) begin
              sraddr  <= raddr_i;
              rwait_o <= 1'b1;
              state   <= WAIT;
            end else begin
              rvalid_o <= 1'b1;
              rdata_o  <= wr_hit_rd ? wdata_i : mem[raddr_i];
            end
          end
        end
        WAIT: begin
          if (wr_hit_wait) begin
            rvalid_o <= 1'b1;
            rdata_o  <= wdata_i;
            rwait_o  <= 1'b0;
            state    <= IDLE;
          end else begin
            rwait_o <= 1'b1;
          end
        end
        default: begin
          rwait_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_regfile_sb.sv
// Scoreboard bench for acc_regfile_sb: directed scenarios followed by random
// traffic, checked against a behavioural model of the register file.
module tb_acc_regfile_sb;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rreq_i = 1'b0;
  logic [4:0]  raddr_i = '0;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        rwait_o;
  logic        wren_i = 1'b0;
  logic [4:0]  waddr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        issue_valid_i = 1'b0;
  logic [4:0]  issue_tag_i = '0;
  logic [31:0] pending_o;
  logic        busy_o;
  logic        err_o;

  acc_regfile_sb #(.NREGS(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rreq_i(rreq_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .rvalid_o(rvalid_o), .rwait_o(rwait_o),
    .wren_i(wren_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .issue_valid_i(issue_valid_i), .issue_tag_i(issue_tag_i),
    .pending_o(pending_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mem_m [32];
  logic [31:0] pend_m = '0;
  logic        err_m = 1'b0;
  logic        stalled_m = 1'b0;
  logic [4:0]  saddr_m = '0;
  logic [31:0] hold_m = '0;
  logic [31:0] exp_q [$];
  logic        armed = 1'b0;
  logic        pend_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a read is served from the storage contents as they were before this
  // edge, unless the same edge writes that address (then the new data is seen).
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      foreach (mem_m[i]) mem_m[i] = '0;
      pend_m = '0;
      err_m = 1'b0;
      stalled_m = 1'b0;
      hold_m = '0;
      exp_q.delete();
      armed = 1'b1;
    end else begin
      if (stalled_m) begin
        if (wren_i && waddr_i == saddr_m) begin
          exp_q.push_back(wdata_i);
          hold_m = wdata_i;
          stalled_m = 1'b0;
        end
      end else if (rreq_i) begin
        pend_rd = pend_m[raddr_i] && !(wren_i && waddr_i == raddr_i);
        if (pend_rd) begin
          stalled_m = 1'b1;
          saddr_m = raddr_i;
        end else begin
          hold_m = (wren_i && waddr_i == raddr_i) ? wdata_i : mem_m[raddr_i];
          exp_q.push_back(hold_m);
        end
      end
      if (wren_i) begin
        mem_m[waddr_i] = wdata_i;
        pend_m[waddr_i] = 1'b0;
      end
      if (issue_valid_i) begin
        if (pend_m[issue_tag_i]) err_m = 1'b1;
        pend_m[issue_tag_i] = 1'b1;
      end
    end
  end

  // Monitor: an output is due whenever the scoreboard holds an entry.
  always @(negedge clk_i) begin
    if (armed) begin
      chk("rvalid", {31'd0, rvalid_o}, {31'd0, exp_q.size() != 0});
      if (rvalid_o && exp_q.size() != 0)
        chk("rdata", rdata_o, exp_q.pop_front());
      else
        chk("rdata_hold", rdata_o, hold_m);
      exp_q.delete();
      chk("rwait", {31'd0, rwait_o}, {31'd0, stalled_m});
      chk("pending", pending_o, pend_m);
      chk("busy", {31'd0, busy_o}, {31'd0, |pend_m});
      chk("err", {31'd0, err_o}, {31'd0, err_m});
      chk("rvalid_rwait_excl", {31'd0, rvalid_o & rwait_o}, 32'd0);
    end
  end

  task automatic drive(input logic rq, input logic [4:0] ra,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iv, input logic [4:0] it);
    @(negedge clk_i);
    rst_ni = 1'b1;
    rreq_i = rq; raddr_i = ra;
    wren_i = we; waddr_i = wa; wdata_i = wd;
    issue_valid_i = iv; issue_tag_i = it;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    rreq_i = 1'b0; wren_i = 1'b0; issue_valid_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    // Plain write then read
    drive(0, 0, 1, 3, 32'h3F80_0000, 0, 0);
    drive(1, 3, 0, 0, 0, 0, 0);
    idle(2);
    // Stall on a pending register, unrelated write, then release
    drive(0, 0, 0, 0, 0, 1, 5);
    drive(1, 5, 0, 0, 0, 0, 0);
    idle(3);
    drive(0, 0, 1, 7, 32'h1234_5678, 0, 0);
    drive(0, 0, 1, 5, 32'h4000_0000, 0, 0);
    idle(2);
    // Same-cycle write releases a pending read without stalling
    drive(0, 0, 0, 0, 0, 1, 9);
    drive(1, 9, 1, 9, 32'hDEAD_BEEF, 0, 0);
    idle(2);
    // Double issue sets sticky error; same-cycle issue+write is legal
    drive(0, 0, 0, 0, 0, 1, 2);
    drive(0, 0, 0, 0, 0, 1, 2);
    idle(2);
    drive(0, 0, 1, 4, 32'hAAAA_5555, 1, 4);
    idle(2);
    // Reset during a stall drops the read
    drive(0, 0, 0, 0, 0, 1, 6);
    drive(1, 6, 0, 0, 0, 0, 0);
    idle(1);
    pulse_reset();
    drive(0, 0, 1, 6, 32'h0BAD_F00D, 0, 0);
    idle(2);
    // Fill and read back all registers back-to-back
    for (int n = 0; n < 32; n++) drive(0, 0, 1, 5'(n), $urandom, 0, 0);
    for (int n = 0; n < 32; n++) drive(1, 5'(n), 0, 0, 0, 0, 0);
    idle(2);
    // Random traffic concentrated on a few addresses to provoke collisions
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0)
        pulse_reset();
      else
        drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
              $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)));
    end
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_regfile_sb.md
Name: acc_regfile_sb

Overview:
- Accelerator-side register file with a per-register pending scoreboard.
- Serves the controller's register read port (raddr/rdata/rvalid) and absorbs FPU write-backs (waddr/wdata/wren, where waddr is the returned FPU tag).
- Each FPU issue marks its destination tag pending; a read of a pending register stalls until the matching write-back arrives, so the controller never consumes stale data.

Parameters:
- NREGS, 32, number of registers; address width AW = $clog2(NREGS).
- DATA_W, 32, register width in bits.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, synchronous, active-low.
- rreq_i  in  1  read request valid.
- raddr_i  in  AW  read address; held stable by the requester while rwait_o=1.
- rdata_o  out  DATA_W  read data, qualified by rvalid_o.
- rvalid_o  out  1  one-cycle pulse when rdata_o is valid.
- rwait_o  out  1  high while a read is stalled on a pending register.
- wren_i  in  1  write-back valid (FPU out_valid).
- waddr_i  in  AW  write address (FPU result tag).
- wdata_i  in  DATA_W  write data (FPU result).
- issue_valid_i  in  1  FPU request accepted this cycle (in_valid & in_ready).
- issue_tag_i  in  AW  destination tag of the accepted request.
- pending_o  out  NREGS  scoreboard bit vector.
- busy_o  out  1  OR of pending_o.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - all registers, pending bits, rdata_o and err_o go to 0;
  - rvalid_o=0, rwait_o=0, FSM goes to IDLE;
  - applies mid-stall too: the stalled read is dropped and never completes.
- Write: on wren_i, mem[waddr_i]<=wdata_i and pending[waddr_i]<=0. A write to a non-pending register is legal and is not an error.
- Issue: on issue_valid_i, pending[issue_tag_i]<=1.
- Issue to a tag already pending with no write to it this cycle: pending stays 1 and err_o<=1 (sticky until reset).
- Same-cycle issue and write to the same address: write data is stored, pending ends at 1, no error (the new issue wins).
- Pending check for reads uses the status after this cycle's write-clear and before this cycle's issue-set. So a same-cycle write to the same address makes the register readable; a same-cycle issue does not block the read.
- FSM states: IDLE and WAIT.
- IDLE, rreq_i=1, register not pending:
  - next cycle rvalid_o=1 and rdata_o=mem[raddr_i];
  - write-first bypass: if wren_i hits raddr_i in the request cycle, rdata_o=wdata_i;
  - stay in IDLE; back-to-back requests give one rvalid_o per cycle, latency 1.
- IDLE, rreq_i=1, register pending:
  - latch raddr into sraddr, go to WAIT;
  - next cycle rwait_o=1, rvalid_o=0.
- WAIT:
  - rreq_i and raddr_i are ignored (address is taken from sraddr).
  - On wren_i with waddr_i==sraddr: next cycle rvalid_o=1, rdata_o=wdata_i, rwait_o=0, go to IDLE.
  - Writes to other addresses update storage normally; the stall continues.
  - An issue to sraddr while waiting has no effect on the stall: the first write-back to sraddr releases it.
- rvalid_o is never high in the same cycle as rwait_o.
- rdata_o holds its last value when rvalid_o=0.
- busy_o and pending_o are registered and reflect the state after the last edge.

Test Plan:
- Reset, then write mem[3]=0x3F800000; next cycle rreq raddr=3 -> following cycle rvalid_o=1, rdata_o=0x3F800000, rwait_o=0.
- Issue tag=5, then rreq raddr=5 -> rwait_o=1 and rvalid_o=0 for 4 cycles. Write waddr=7 during the stall -> still waiting. Write waddr=5 data=0x40000000 -> next cycle rvalid_o=1, rdata_o=0x40000000, pending_o[5]=0, busy_o=0.
- Same cycle: rreq raddr=9, wren waddr=9 wdata=0xDEADBEEF, pending[9]=1 beforehand -> next cycle rvalid_o=1, rdata_o=0xDEADBEEF, no stall.
- Issue tag=2 twice with no write between -> err_o=1 after the second issue and stays 1. Same-cycle issue and write of tag 4 -> pending_o[4]=1, no additional error.
- Issue tag=6, rreq raddr=6 (stall), then assert rst_ni=0 for one cycle -> rvalid_o=0, rwait_o=0, pending_o=0. A later write to 6 produces no rvalid_o.
- Back-to-back reads of addresses 0..31 with nothing pending -> 32 consecutive rvalid_o pulses, each returning mem[n] one cycle after its request.
